// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event queue.
// Holds the button-count limit, the event word layout and the event kind encodings.
package btn_evt_pkg;

  localparam int unsigned NBTN_MAX = 16;
  localparam int unsigned EVT_W    = 5;

  localparam logic KIND_PRESS   = 1'b1;
  localparam logic KIND_RELEASE = 1'b0;

  // Event word layout: {kind, idx[3:0]}
  localparam int unsigned EVT_KIND_POS = 4;
  localparam int unsigned EVT_IDX_MSB  = 3;
  localparam int unsigned EVT_IDX_LSB  = 0;

  typedef struct packed {
    logic       kind;
    logic [3:0] idx;
  } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through event FIFO.
// Ports:
//   CLK, nRST      clock, synchronous active-low reset
//   wr_en/wr_data  push request and data; a push while full is accepted only with a same-cycle pop
//   rd_en          pop request; ignored while empty
//   rd_data        head entry, 0 while empty
//   count          number of stored entries
//   full, empty    occupancy flags
module evt_fifo
  import btn_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   wr_en,
  input  logic [EVT_W-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [EVT_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    do_rd   = rd_en && !empty;
    // Full is writable only when the head leaves in the same cycle.
    do_wr   = wr_en && (!full || do_rd);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Pointers are power-of-two wide so increment wraps naturally.
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    else if (do_rd && !do_wr) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; empty gating hides stale contents.
  always_ff @(posedge CLK) begin
    if (do_wr) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rptr_q];
  assign count   = count_q;

endmodule

// File: rtl/btn_event_queue.sv
// Button event queue: captures one-cycle press/release pulses into pending registers,
// arbitrates one event per cycle (presses first, lowest index first) and queues them
// for software in a first-word-fall-through FIFO.
// Ports:
//   CLK, nRST        clock, synchronous active-low reset
//   BOUTN, BOUTP     press / release pulses, one bit per button
//   evt_pop          consume head event (ignored when empty)
//   ovf_clr          clear the sticky overflow flag
//   evt_valid        queue non-empty
//   evt_data         head event {kind, idx}, 0 when empty
//   evt_count        number of queued events
//   overflow         sticky, set when an event is dropped
module btn_event_queue
  import btn_evt_pkg::*;
#(
  parameter int unsigned NBTN  = 11,  // at most NBTN_MAX
  parameter int unsigned DEPTH = 8    // power of two, at least 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NBTN-1:0]        BOUTN,
  input  logic [NBTN-1:0]        BOUTP,
  input  logic                   evt_pop,
  input  logic                   ovf_clr,
  output logic                   evt_valid,
  output logic [EVT_W-1:0]       evt_data,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow
);

  logic [NBTN-1:0] pend_n_q, pend_n_d;
  logic [NBTN-1:0] pend_p_q, pend_p_d;
  logic [NBTN-1:0] grant_n, grant_p;
  logic            gnt_valid;
  evt_t            gnt_evt;
  logic            fifo_wr, fifo_full, fifo_empty, drop;
  logic            ovf_q, ovf_d;

  // Priority arbiter: any pending press beats every pending release.
  always_comb begin
    grant_n   = '0;
    grant_p   = '0;
    gnt_valid = 1'b0;
    gnt_evt   = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      if (pend_n_q[i] && !gnt_valid) begin
        gnt_valid    = 1'b1;
        grant_n[i]   = 1'b1;
        gnt_evt.kind = KIND_PRESS;
        gnt_evt.idx  = 4'(i);
      end
    end
    for (int i = 0; i < int'(NBTN); i++) begin
      if (pend_p_q[i] && !gnt_valid) begin
        gnt_valid    = 1'b1;
        grant_p[i]   = 1'b1;
        gnt_evt.kind = KIND_RELEASE;
        gnt_evt.idx  = 4'(i);
      end
    end
  end

  always_comb begin
    // Granted bit clears whether or not the FIFO accepted it; new pulses merge.
    pend_n_d = (pend_n_q & ~grant_n) | BOUTN;
    pend_p_d = (pend_p_q & ~grant_p) | BOUTP;
    // At full, a same-cycle pop frees the slot (evt_pop at full implies valid).
    fifo_wr  = gnt_valid && (!fifo_full || evt_pop);
    drop     = gnt_valid && !fifo_wr;
    ovf_d    = ovf_q;
    if (drop) ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pend_n_q <= '0;
      pend_p_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_n_q <= pend_n_d;
      pend_p_q <= pend_p_d;
      ovf_q    <= ovf_d;
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .CLK     (CLK),
    .nRST    (nRST),
    .wr_en   (fifo_wr),
    .wr_data (gnt_evt),
    .rd_en   (evt_pop),
    .rd_data (evt_data),
    .count   (evt_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_btn_event_queue.sv
// Self-checking bench for btn_event_queue (NBTN=11, DEPTH=8).
module tb_btn_event_queue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [10:0] BOUTN, BOUTP;
  logic        evt_pop, ovf_clr;
  logic        evt_valid;
  logic [4:0]  evt_data;
  logic [3:0]  evt_count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  btn_event_queue #(
    .NBTN  (11),
    .DEPTH (8)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .BOUTN     (BOUTN),
    .BOUTP     (BOUTP),
    .evt_pop   (evt_pop),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [10:0] boutn;
    logic [10:0] boutp;
    logic        pop;
    logic        valid;
    logic [4:0]  data;
    logic [3:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] d,
                         input logic [3:0] c, input logic o);
    chk({tag, ".valid"}, int'(evt_valid), int'(v));
    chk({tag, ".data"},  int'(evt_data),  int'(d));
    chk({tag, ".count"}, int'(evt_count), int'(c));
    chk({tag, ".ovf"},   int'(overflow),  int'(o));
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    BOUTN   = '0;
    BOUTP   = '0;
    evt_pop = 1'b0;
    ovf_clr = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();

    // Reset with random stimulus on the inputs
    for (int i = 0; i < 3; i++) begin
      BOUTN   = 11'($urandom);
      BOUTP   = 11'($urandom);
      evt_pop = 1'($urandom);
      ovf_clr = 1'($urandom);
      tick();
      chk_out($sformatf("reset%0d", i), 1'b0, 5'h00, 4'd0, 1'b0);
    end
    idle_inputs();
    nRST = 1'b1;

    // boutn, boutp, pop, valid, data, cnt, ovf
    // Single event with 2-edge latency
    vecs.push_back('{11'h004, 11'h000, 1'b0, 1'b0, 5'h00, 4'd0, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b0, 1'b1, 5'h12, 4'd1, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b1, 1'b0, 5'h00, 4'd0, 1'b0});
    // Arbitration: presses ascending, then release
    vecs.push_back('{11'h041, 11'h400, 1'b0, 1'b0, 5'h00, 4'd0, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b0, 1'b1, 5'h10, 4'd1, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b0, 1'b1, 5'h10, 4'd2, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b0, 1'b1, 5'h10, 4'd3, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b1, 1'b1, 5'h16, 4'd2, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b1, 1'b1, 5'h0A, 4'd1, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b1, 1'b0, 5'h00, 4'd0, 1'b0});
    // Pop while empty is ignored
    vecs.push_back('{11'h000, 11'h000, 1'b1, 1'b0, 5'h00, 4'd0, 1'b0});
    // Release of button 0 encodes as 5'h00 but is valid
    vecs.push_back('{11'h000, 11'h001, 1'b0, 1'b0, 5'h00, 4'd0, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b0, 1'b1, 5'h00, 4'd1, 1'b0});
    vecs.push_back('{11'h000, 11'h008, 1'b1, 1'b0, 5'h00, 4'd0, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b0, 1'b1, 5'h03, 4'd1, 1'b0});
    // Simultaneous push and pop below full
    vecs.push_back('{11'h010, 11'h000, 1'b0, 1'b1, 5'h03, 4'd1, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b1, 1'b1, 5'h14, 4'd1, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b1, 1'b0, 5'h00, 4'd0, 1'b0});
    // Pending merge: bit 1 pulsed again while still pending
    vecs.push_back('{11'h003, 11'h000, 1'b0, 1'b0, 5'h00, 4'd0, 1'b0});
    vecs.push_back('{11'h002, 11'h000, 1'b0, 1'b1, 5'h10, 4'd1, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b0, 1'b1, 5'h10, 4'd2, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b0, 1'b1, 5'h10, 4'd2, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b1, 1'b1, 5'h11, 4'd1, 1'b0});
    vecs.push_back('{11'h000, 11'h000, 1'b1, 1'b0, 5'h00, 4'd0, 1'b0});

    foreach (vecs[i]) begin
      BOUTN   = vecs[i].boutn;
      BOUTP   = vecs[i].boutp;
      evt_pop = vecs[i].pop;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].cnt, vecs[i].ovf);
    end
    idle_inputs();

    // Overflow: 11 presses at once; clear held throughout but set wins on drops
    BOUTN = 11'h7FF;
    tick();
    BOUTN   = '0;
    ovf_clr = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk_out("ovf_pre", 1'b1, 5'h10, 4'd8, 1'b0);
    tick();
    chk("ovf_first_drop", int'(overflow), 1);
    tick();
    tick();
    chk_out("ovf_full", 1'b1, 5'h10, 4'd8, 1'b1);
    tick();
    chk("ovf_clr", int'(overflow), 0);
    ovf_clr = 1'b0;

    // Full plus pop: pop aligned with the grant cycle of a new press
    BOUTN = 11'h100;
    tick();
    BOUTN = '0;
    chk_out("fp_pend", 1'b1, 5'h10, 4'd8, 1'b0);
    evt_pop = 1'b1;
    tick();
    chk_out("fp_swap", 1'b1, 5'h11, 4'd8, 1'b0);
    for (int i = 2; i < 9; i++) begin
      tick();
      chk($sformatf("drain%0d", i), int'(evt_data), (i < 8) ? (8'h10 + i) : 8'h18);
    end
    tick();
    chk_out("drain_end", 1'b0, 5'h00, 4'd0, 1'b0);
    evt_pop = 1'b0;

    // Reset mid-drain discards queued and pending events
    BOUTN = 11'h0FF;
    tick();
    BOUTN = '0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_pre_count", int'(evt_count), 5);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    chk_out("rst_mid", 1'b0, 5'h00, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rst_after%0d", i), 1'b0, 5'h00, 4'd0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
